// File: rtl/vrp_arb_lock_rr_if.sv
// Requester/downstream bundle for the burst-locking round-robin arbiter.
// Combinational path end to end; the arbiter stalls requesters by withholding v_in_rdy.
interface vrp_arb_lock_rr_if #(
  parameter int BIN_WIDTH = 2,
  parameter int CNT_WIDTH = 4
);
  localparam int OH_WIDTH = 1 << BIN_WIDTH;

  logic [OH_WIDTH-1:0]  v_in_vld;
  logic [OH_WIDTH-1:0]  v_in_last;
  logic [OH_WIDTH-1:0]  v_in_rdy;
  logic                 out_vld;
  logic                 out_rdy;
  logic                 out_last;
  logic [BIN_WIDTH-1:0] out_idx;
  logic                 out_lock;
  logic [CNT_WIDTH-1:0] out_beat;

  modport master (
    output v_in_vld, v_in_last, out_rdy,
    input  v_in_rdy, out_vld, out_last, out_idx, out_lock, out_beat
  );

  modport slave (
    input  v_in_vld, v_in_last, out_rdy,
    output v_in_rdy, out_vld, out_last, out_idx, out_lock, out_beat
  );
endinterface

// File: rtl/vrp_arb_lock_rr.sv
// Round-robin arbiter that keeps a winner until its last beat; zero-latency grant path.
// A stalled offer freezes the choice (HOLD) so requesters never see the grant move under them.
module vrp_arb_lock_rr #(
  parameter int BIN_WIDTH = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  vrp_arb_lock_rr_if.slave   bus
);
  localparam int OH_WIDTH = 1 << BIN_WIDTH;

  typedef enum logic [1:0] {ST_ARB, ST_HOLD, ST_LOCK} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] owner_q, owner_d;
  logic [OH_WIDTH-1:0]  prev_oh_q, prev_oh_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic [OH_WIDTH-1:0]  hi_mask, req_hi, sel_oh, g_oh, rdy_oh;
  logic [BIN_WIDTH-1:0] sel_idx, g_idx;
  logic                 seen, vld_w, last_w, fire;

  // hi_mask[i] is set when prev_oh has a bit strictly below i.
  always_comb begin
    hi_mask = '0;
    seen    = 1'b0;
    for (int i = 0; i < OH_WIDTH; i++) begin
      hi_mask[i] = seen;
      seen       = seen | prev_oh_q[i];
    end
    req_hi  = bus.v_in_vld & hi_mask;
    sel_idx = '0;
    for (int i = OH_WIDTH - 1; i >= 0; i--) begin
      if (bus.v_in_vld[i]) sel_idx = BIN_WIDTH'(i);
    end
    if (|req_hi) begin
      for (int i = OH_WIDTH - 1; i >= 0; i--) begin
        if (req_hi[i]) sel_idx = BIN_WIDTH'(i);
      end
    end
    sel_oh = OH_WIDTH'(1) << sel_idx;
  end

  always_comb begin
    g_idx  = (state_q == ST_ARB) ? sel_idx : owner_q;
    g_oh   = OH_WIDTH'(1) << g_idx;
    vld_w  = (state_q == ST_ARB) ? (|bus.v_in_vld) : bus.v_in_vld[g_idx];
    last_w = bus.v_in_last[g_idx];
    fire   = vld_w & bus.out_rdy;
    rdy_oh = fire ? g_oh : '0;
  end

  assign bus.out_vld  = vld_w;
  assign bus.out_last = last_w;
  assign bus.out_idx  = g_idx;
  assign bus.v_in_rdy = rdy_oh;
  assign bus.out_lock = (state_q != ST_ARB);
  assign bus.out_beat = beat_cnt_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prev_oh_d  = prev_oh_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (vld_w && !bus.out_rdy) begin
          state_d = ST_HOLD;
          owner_d = sel_idx;
        end else if (fire && !last_w) begin
          state_d    = ST_LOCK;
          owner_d    = sel_idx;
          beat_cnt_d = CNT_WIDTH'(1);
        end else if (fire) begin
          prev_oh_d  = sel_oh;
          beat_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (fire && !last_w) begin
          state_d    = ST_LOCK;
          beat_cnt_d = CNT_WIDTH'(1);
        end else if (fire) begin
          state_d    = ST_ARB;
          prev_oh_d  = g_oh;
          beat_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (fire && last_w) begin
          state_d    = ST_ARB;
          prev_oh_d  = g_oh;
          beat_cnt_d = '0;
        end else if (fire && !(&beat_cnt_q)) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Reset leaves index OH_WIDTH-1 as the previous winner so index 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      owner_q    <= '0;
      prev_oh_q  <= {1'b1, {(OH_WIDTH-1){1'b0}}};
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prev_oh_q  <= prev_oh_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule
